div_rr_scheduler: RTL and testbench

- Shares one iterative restoring divider among NREQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- Sequences the shared core one quotient bit per cycle.
- Returns quotient and remainder on a single response channel, tagged with the requester id; the response is held until it is accepted.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_iter_core.sv | 64 ++++++
 rtl/div_rr_scheduler.sv | 156 +++++++++++++++
 tb/tb_div_rr_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the round-robin divider
//               scheduler and its iterative divider core.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREQ  = 4;

    // Quotient reported for a zero divisor; sliced to WIDTH by the user
    // (supports operand widths up to 64 bits).
    localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_core
// Description : Unsigned restoring divider, one quotient bit per cycle.
//               quotient/remainder/done describe the step being taken in
//               the current cycle, so the caller captures the final result
//               on the same edge that completes the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_core
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;   // partial remainder (always < divisor)
    logic [WIDTH-1:0] r_quo;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_shift; // WIDTH+1 bits so the compare cannot overflow
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    // Difference is always below the divisor, so the low WIDTH bits suffice
    assign w_sub     = w_shift[WIDTH-1:0] - r_div;
    assign remainder = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign quotient  = {r_quo[WIDTH-2:0], w_ge};
    assign done      = (r_cnt == CW'(1));

    // Load operands on start, then perform one restoring step per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
            r_cnt <= CW'(WIDTH);
        end else if (r_cnt != '0) begin
            r_rem <= remainder;
            r_quo <= quotient;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule : div_iter_core
`default_nettype wire

// File: rtl/div_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : div_rr_scheduler
// Description : Round-robin arbiter sharing one iterative divider among
//               NREQ requesters. Results are returned on a single tagged
//               response channel and held until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module div_rr_scheduler
    import div_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NREQ  = DEFAULT_NREQ,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_div0,
    output logic                  busy
);

    div_state_e       r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_quotient;
    logic [WIDTH-1:0] r_rsp_remainder;
    logic             r_rsp_div0;

    logic             w_found;
    logic [IDW-1:0]   w_grant_id;
    logic [IDW-1:0]   w_ptr_next;
    logic [WIDTH-1:0] w_sel_dividend;
    logic [WIDTH-1:0] w_sel_divisor;
    logic             w_accept;
    logic             w_core_start;
    logic [WIDTH-1:0] w_core_quotient;
    logic [WIDTH-1:0] w_core_remainder;
    logic             w_core_done;

    // Round-robin search starting at r_rr_ptr; walking the offsets downward
    // lets the smallest offset with a valid request win.
    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                w_found    = 1'b1;
                w_grant_id = IDW'(idx);
            end
        end
    end

    // One-hot ready on the grant, only while idle
    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_found) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    assign w_accept       = (r_state == IDLE) && w_found;
    assign w_sel_dividend = req_dividend[w_grant_id*WIDTH +: WIDTH];
    assign w_sel_divisor  = req_divisor[w_grant_id*WIDTH +: WIDTH];
    assign w_core_start   = w_accept && (w_sel_divisor != '0);
    assign w_ptr_next     = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);

    div_iter_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (w_core_start),
        .dividend  (w_sel_dividend),
        .divisor   (w_sel_divisor),
        .quotient  (w_core_quotient),
        .remainder (w_core_remainder),
        .done      (w_core_done)
    );

    // Scheduler FSM: accept, run the core, hold the response until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_rr_ptr        <= '0;
            r_id            <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= '0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_div0      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id     <= w_grant_id;
                        r_rr_ptr <= w_ptr_next;
                        if (w_sel_divisor == '0) begin
                            // Divide by zero short-circuits straight to DONE
                            r_state         <= DONE;
                            r_rsp_valid     <= 1'b1;
                            r_rsp_id        <= w_grant_id;
                            r_rsp_quotient  <= DIV0_QUOTIENT[WIDTH-1:0];
                            r_rsp_remainder <= w_sel_dividend;
                            r_rsp_div0      <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_core_done) begin
                        r_state         <= DONE;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_id        <= r_id;
                        r_rsp_quotient  <= w_core_quotient;
                        r_rsp_remainder <= w_core_remainder;
                        r_rsp_div0      <= 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_div0      = r_rsp_div0;
    assign busy          = (r_state != IDLE);

endmodule : div_rr_scheduler
`default_nettype wire

// File: tb/tb_div_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_rr_scheduler
// Description : Directed, table-driven bench for div_rr_scheduler
//               (WIDTH=8, NREQ=4) plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_rr_scheduler;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_quotient;
    logic [W-1:0]   rsp_remainder;
    logic           rsp_div0;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_rr_scheduler #(
        .WIDTH         (W),
        .NREQ          (N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_div0      (rsp_div0),
        .busy          (busy)
    );

    typedef struct {
        int id;
        int dvd;
        int dvs;
        int q;
        int r;
        int d0;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_op(input int id, input int dvd, input int dvs);
        req_dividend[id*W +: W] = W'(dvd);
        req_divisor[id*W +: W]  = W'(dvs);
    endtask

    // Called on a negedge; counts negedges until rsp_valid (bounded)
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: actual=%0d required=1", rsp_valid);
        end
    endtask

    // Acknowledge the held response, then confirm it was retired
    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_ack", 32'(rsp_valid), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] hold_q, hold_r, hold_id;

        tbl[0] = '{0, 100,   7,  14,   2, 0};
        tbl[1] = '{2,  45,   0, 255,  45, 1};
        tbl[2] = '{1, 255,   1, 255,   0, 0};
        tbl[3] = '{3,   5,   9,   0,   5, 0};
        tbl[4] = '{0, 255, 255,   1,   0, 0};
        tbl[5] = '{2, 128,   2,  64,   0, 0};
        tbl[6] = '{3, 200,  13,  15,   5, 0};
        tbl[7] = '{1,   0,   5,   0,   0, 0};
        tbl[8] = '{3,   0,   0, 255,   0, 1};

        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b0;
        do_reset();

        // Reset state
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_q", 32'(rsp_quotient), 0);
        chk("rst_rsp_r", 32'(rsp_remainder), 0);
        chk("rst_rsp_div0", 32'(rsp_div0), 0);

        // Table-driven single-requester operations
        for (int i = 0; i < 9; i++) begin
            set_op(tbl[i].id, tbl[i].dvd, tbl[i].dvs);
            req_valid = N'(1 << tbl[i].id);
            #1;
            chk("vec_req_ready", 32'(req_ready), 32'(1 << tbl[i].id));
            @(posedge clk);
            @(negedge clk);
            req_valid = '0;
            wait_rsp(lat);
            chk("vec_latency", 32'(lat), (tbl[i].d0 != 0) ? 1 : W + 1);
            chk("vec_id", 32'(rsp_id), 32'(tbl[i].id));
            chk("vec_q", 32'(rsp_quotient), 32'(tbl[i].q));
            chk("vec_r", 32'(rsp_remainder), 32'(tbl[i].r));
            chk("vec_div0", 32'(rsp_div0), 32'(tbl[i].d0));
            ack_rsp();
            chk("vec_busy_after_ack", 32'(busy), 0);
        end

        // All requesters valid: served in id order 0,1,2,3 then 0
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 50 + 10 * i, i + 3);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            wait_rsp(lat);
            chk("rr_id", 32'(rsp_id), 32'(n % N));
            case (n % N)
                0: begin chk("rr_q", 32'(rsp_quotient), 16); chk("rr_r", 32'(rsp_remainder), 2); end
                1: begin chk("rr_q", 32'(rsp_quotient), 15); chk("rr_r", 32'(rsp_remainder), 0); end
                2: begin chk("rr_q", 32'(rsp_quotient), 14); chk("rr_r", 32'(rsp_remainder), 0); end
                default: begin chk("rr_q", 32'(rsp_quotient), 13); chk("rr_r", 32'(rsp_remainder), 2); end
            endcase
            if (n == 3) begin
                // Pointer wraps to 0 after serving 3: 0 beats 3
                req_valid = 4'b1001;
                @(negedge clk);
                chk("rr_wrap_grant", 32'(req_ready), 32'b0001);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = '0;
        @(negedge clk);
        if (rsp_valid === 1'b1) ack_rsp();

        // Backpressure: response held while another requester waits
        do_reset();
        set_op(1, 100, 7);
        set_op(2, 77, 8);
        req_valid = 4'b0010;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0100;
        wait_rsp(lat);
        hold_q  = 32'(rsp_quotient);
        hold_r  = 32'(rsp_remainder);
        hold_id = 32'(rsp_id);
        chk("bp_id", hold_id, 1);
        chk("bp_q", hold_q, 14);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_q", 32'(rsp_quotient), 14);
            chk("bp_hold_r", 32'(rsp_remainder), 2);
            chk("bp_hold_id", 32'(rsp_id), 1);
            chk("bp_no_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_released", 32'(rsp_valid), 0);
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(lat);
        chk("bp2_id", 32'(rsp_id), 2);
        chk("bp2_q", 32'(rsp_quotient), 9);
        chk("bp2_r", 32'(rsp_remainder), 5);
        ack_rsp();

        // Reset in the 3rd RUN cycle (rr_ptr is 3 here)
        set_op(2, 90, 4);
        req_valid = 4'b0100;
        #1;
        chk("mr_grant2", 32'(req_ready), 32'b0100);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_op(1, 99, 10);
        set_op(3, 17, 3);
        req_valid = 4'b1010;
        #1;
        chk("mr_rsp_valid", 32'(rsp_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_grant_from_ptr0", 32'(req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(lat);
        chk("mr_id", 32'(rsp_id), 1);
        chk("mr_q", 32'(rsp_quotient), 9);
        chk("mr_r", 32'(rsp_remainder), 9);
        ack_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div_rr_scheduler
`default_nettype wire
